// File: rtl/prio_encoder42_pkg.sv
// prio_enc42_pkg: shared types and constants for the 4-to-2 priority encoder.
//   enc_state_t : handshake FSM states (IDLE, OFFER)
//   N_REQ       : number of request lines
//   CODE_W      : width of the encoded index
//   onehot()    : expands a code into its one-hot request line
package prio_enc42_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } enc_state_t;

  // Expand an encoded index into the matching one-hot request line.
  function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] code);
    onehot = 4'b0001 << code;
  endfunction

endpackage

// File: rtl/prio_encoder42_if.sv
// prio_encoder42_if: request/offer bundle of the 4-to-2 priority encoder.
//   en, d, ready       : driven by the producer/consumer side (master)
//   y, valid, pending  : driven by the encoder (slave)
interface prio_encoder42_if;
  import prio_enc42_pkg::*;

  logic              en;
  logic [N_REQ-1:0]  d;
  logic              ready;
  logic [CODE_W-1:0] y;
  logic              valid;
  logic [N_REQ-1:0]  pending;

  modport master (output en, d, ready, input y, valid, pending);
  modport slave  (input en, d, ready, output y, valid, pending);

endinterface

// File: rtl/prio_encoder42_pick.sv
// prio_pick: combinational picker selecting one index out of a pending mask.
//   pend : pending request mask (must be non-zero for a meaningful result)
//   last : previously granted index (only with PRIO_ENC42_ROUND_ROBIN_EN)
//   idx  : chosen index
// Build option PRIO_ENC42_ROUND_ROBIN_EN: search last-1, last-2, last-3, last
// (mod 4), so the just-granted index has lowest priority. Without it the
// priority is fixed, 3 highest and 0 lowest.
module prio_pick
  import prio_enc42_pkg::*;
(
  input  logic [N_REQ-1:0]  pend,
`ifdef PRIO_ENC42_ROUND_ROBIN_EN
  input  logic [CODE_W-1:0] last,
`endif
  output logic [CODE_W-1:0] idx
);

`ifdef PRIO_ENC42_ROUND_ROBIN_EN
  logic              found_s;
  logic [CODE_W-1:0] cand_s;

  // Rotating search: first pending index walking downward from last-1.
  always_comb begin
    idx     = 2'd0;
    found_s = 1'b0;
    cand_s  = 2'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = last - CODE_W'(k);
      if (!found_s && pend[cand_s]) begin
        idx     = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`else
  // Fixed priority search: highest set index wins.
  always_comb begin
    if (pend[3]) begin
      idx = 2'd3;
    end else if (pend[2]) begin
      idx = 2'd2;
    end else if (pend[1]) begin
      idx = 2'd1;
    end else if (pend[0]) begin
      idx = 2'd0;
    end else begin
      idx = 2'd0;
    end
  end
`endif

endmodule

// File: rtl/prio_encoder42.sv
// prio_encoder42: registered 4-to-2 priority encoder with sticky request
// latching and a valid/ready output handshake.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : prio_encoder42_if.slave (en, d, ready in; y, valid, pending out)
// Build option PRIO_ENC42_ROUND_ROBIN_EN selects rotating priority and adds
// the last-granted register; default is fixed priority 3 > 2 > 1 > 0.
module prio_encoder42
  import prio_enc42_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  prio_encoder42_if.slave   bus
);

  enc_state_t        state_r;
  logic [CODE_W-1:0] y_r;
  logic              valid_r;
  logic [N_REQ-1:0]  pend_r;
  logic [N_REQ-1:0]  clr_s;
  logic [N_REQ-1:0]  cap_s;
  logic [N_REQ-1:0]  pend_nxt_s;
  logic [CODE_W-1:0] pick_s;
`ifdef PRIO_ENC42_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_r;
`endif

  prio_pick u_pick (
    .pend (pend_r),
`ifdef PRIO_ENC42_ROUND_ROBIN_EN
    .last (last_r),
`endif
    .idx  (pick_s)
  );

  // Capture mask, retire mask and next pending value. Clearing is applied
  // before capture so a request re-arriving on its transfer edge re-arms.
  always_comb begin
    if (bus.en) begin
      cap_s = bus.d;
    end else begin
      cap_s = 4'b0000;
    end
    if (valid_r && bus.ready) begin
      clr_s = onehot(y_r);
    end else begin
      clr_s = 4'b0000;
    end
    pend_nxt_s = (pend_r & ~clr_s) | cap_s;
  end

  // Pending register, handshake FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      y_r     <= 2'd0;
      valid_r <= 1'b0;
      pend_r  <= 4'b0000;
`ifdef PRIO_ENC42_ROUND_ROBIN_EN
      last_r  <= 2'd0;
`endif
    end else begin
      pend_r <= pend_nxt_s;
      case (state_r)
        IDLE: begin
          // pick sees the registered mask, never raw d
          if (pend_r != 4'b0000) begin
            y_r     <= pick_s;
            valid_r <= 1'b1;
            state_r <= OFFER;
          end else begin
            valid_r <= 1'b0;
          end
        end
        OFFER: begin
          // y and valid hold until accepted; new requests never preempt
          if (bus.ready) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
`ifdef PRIO_ENC42_ROUND_ROBIN_EN
            last_r  <= y_r;
`endif
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.y       = y_r;
  assign bus.valid   = valid_r;
  assign bus.pending = pend_r;

endmodule

// File: tb/tb_prio_encoder42.sv
// tb_prio_encoder42: directed scenarios plus randomized traffic checked
// against a behavioural model of the request/offer rules.
module tb_prio_encoder42;
  import prio_enc42_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  prio_encoder42_if bus ();

  prio_encoder42 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  logic [3:0] m_pend;
  logic       m_valid;
  logic [1:0] m_y;
  logic [1:0] m_last;

  // Choose the index to offer: fixed highest-first, or rotating after last.
  function automatic logic [1:0] m_pick(input logic [3:0] p, input logic [1:0] l);
    logic [1:0] r;
    r = 2'd0;
`ifdef PRIO_ENC42_ROUND_ROBIN_EN
    for (int k = 4; k >= 1; k--) begin
      int c;
      c = ((int'(l) - k) % 4 + 4) % 4;
      if (p[c]) r = 2'(c);
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (p[i]) r = 2'(i);
    end
`endif
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic       hs;
    logic [1:0] oy;
    if (rst) begin
      m_pend = 4'b0000; m_valid = 1'b0; m_y = 2'd0; m_last = 2'd0;
    end else begin
      hs = m_valid && bus.ready;
      oy = m_y;
      if (m_valid) begin
        if (bus.ready) begin
          m_valid = 1'b0;
          m_last  = m_y;
        end
      end else if (m_pend != 4'b0000) begin
        m_y     = m_pick(m_pend, m_last);
        m_valid = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (hs && i == int'(oy)) m_pend[i] = 1'b0;
        if (bus.en && bus.d[i]) m_pend[i] = 1'b1;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are then sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.d = 4'b0000; bus.ready = 1'b0;
    tick();
    tick();
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", bus.pending); end
    total++; if (bus.y !== 2'b00) begin bad++; $display("FAIL reset_y got=%b exp=00", bus.y); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.en = 1'b1; bus.d = 4'b0100; bus.ready = 1'b1;
    tick();
    total++; if (bus.pending !== 4'b0100 || bus.valid !== 1'b0) begin bad++; $display("FAIL single_capture pend=%b valid=%b exp pend=0100 valid=0", bus.pending, bus.valid); end
    bus.d = 4'b0000;
    tick();
    total++; if (bus.valid !== 1'b1 || bus.y !== 2'b10) begin bad++; $display("FAIL single_offer valid=%b y=%b exp valid=1 y=10", bus.valid, bus.y); end
    tick();
    total++; if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin bad++; $display("FAIL single_retire valid=%b pend=%b exp valid=0 pend=0000", bus.valid, bus.pending); end
  endtask

  task automatic test_two();
    bus.en = 1'b1; bus.d = 4'b1010; bus.ready = 1'b1;
    tick();
    bus.d = 4'b0000;
    tick();
    total++; if (bus.valid !== 1'b1 || bus.y !== 2'b11) begin bad++; $display("FAIL two_first valid=%b y=%b exp valid=1 y=11", bus.valid, bus.y); end
    tick();
    total++; if (bus.valid !== 1'b0 || bus.pending !== 4'b0010) begin bad++; $display("FAIL two_bubble valid=%b pend=%b exp valid=0 pend=0010", bus.valid, bus.pending); end
    tick();
    total++; if (bus.valid !== 1'b1 || bus.y !== 2'b01) begin bad++; $display("FAIL two_second valid=%b y=%b exp valid=1 y=01", bus.valid, bus.y); end
    tick();
    total++; if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin bad++; $display("FAIL two_done valid=%b pend=%b exp valid=0 pend=0000", bus.valid, bus.pending); end
  endtask

  task automatic test_hold();
    bus.en = 1'b1; bus.d = 4'b0010; bus.ready = 1'b0;
    tick();
    bus.d = 4'b0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.d = (i == 0) ? 4'b1000 : 4'b0000;
      tick();
      total++; if (bus.valid !== 1'b1 || bus.y !== 2'b01) begin bad++; $display("FAIL hold_stable cyc=%0d valid=%b y=%b exp valid=1 y=01", i, bus.valid, bus.y); end
    end
    total++; if (bus.pending !== 4'b1010) begin bad++; $display("FAIL hold_pending got=%b exp=1010", bus.pending); end
    bus.ready = 1'b1;
    tick();
    total++; if (bus.valid !== 1'b0 || bus.pending !== 4'b1000) begin bad++; $display("FAIL hold_retire valid=%b pend=%b exp valid=0 pend=1000", bus.valid, bus.pending); end
    tick();
    total++; if (bus.valid !== 1'b1 || bus.y !== 2'b11) begin bad++; $display("FAIL hold_next valid=%b y=%b exp valid=1 y=11", bus.valid, bus.y); end
    tick();
  endtask

  task automatic test_rearm();
    bus.en = 1'b1; bus.d = 4'b0001; bus.ready = 1'b1;
    tick();
    bus.d = 4'b0000;
    tick();
    total++; if (bus.valid !== 1'b1 || bus.y !== 2'b00) begin bad++; $display("FAIL rearm_offer valid=%b y=%b exp valid=1 y=00", bus.valid, bus.y); end
    bus.d = 4'b0001;
    tick();
    total++; if (bus.valid !== 1'b0 || bus.pending !== 4'b0001) begin bad++; $display("FAIL rearm_keep valid=%b pend=%b exp valid=0 pend=0001", bus.valid, bus.pending); end
    bus.d = 4'b0000;
    tick();
    total++; if (bus.valid !== 1'b1 || bus.y !== 2'b00) begin bad++; $display("FAIL rearm_reoffer valid=%b y=%b exp valid=1 y=00", bus.valid, bus.y); end
    tick();
  endtask

  task automatic test_en_rst();
    bus.en = 1'b1; bus.d = 4'b0100; bus.ready = 1'b0;
    tick();
    bus.en = 1'b0; bus.d = 4'b1111;
    tick();
    tick();
    total++; if (bus.pending !== 4'b0100 || bus.valid !== 1'b1 || bus.y !== 2'b10) begin bad++; $display("FAIL en_block pend=%b valid=%b y=%b exp pend=0100 valid=1 y=10", bus.pending, bus.valid, bus.y); end
    rst = 1'b1; bus.en = 1'b1; bus.ready = 1'b1;
    tick();
    total++; if (bus.valid !== 1'b0 || bus.pending !== 4'b0000 || bus.y !== 2'b00) begin bad++; $display("FAIL rst_mid_offer valid=%b pend=%b y=%b exp 0/0000/00", bus.valid, bus.pending, bus.y); end
    rst = 1'b0; bus.d = 4'b0000; bus.ready = 1'b0;
  endtask

  task automatic test_saturate();
    int         n;
    logic [1:0] exp_y;
    n = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.en = 1'b1; bus.d = 4'b1111; bus.ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.valid === 1'b1) begin
`ifdef PRIO_ENC42_ROUND_ROBIN_EN
        exp_y = 2'(3 - n);
`else
        exp_y = 2'd3;
`endif
        total++; if (bus.y !== exp_y) begin bad++; $display("FAIL saturate_code n=%0d got=%0d exp=%0d", n, bus.y, exp_y); end
        n++;
      end
    end
    total++; if (n < 8) begin bad++; $display("FAIL saturate_rate offers=%0d exp>=8", n); end
    bus.d = 4'b0000;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 40) == 0);
      bus.en    = ($urandom_range(0, 3) != 0);
      bus.d     = 4'($urandom & $urandom & $urandom);
      bus.ready = ($urandom_range(0, 2) != 0);
      tick();
      total++;
      if (bus.valid !== m_valid || bus.y !== m_y || bus.pending !== m_pend) begin
        bad++;
        $display("FAIL random cyc=%0d got v=%b y=%0d p=%b exp v=%b y=%0d p=%b",
                 c, bus.valid, bus.y, bus.pending, m_valid, m_y, m_pend);
      end
    end
    rst = 1'b0; bus.en = 1'b0; bus.d = 4'b0000; bus.ready = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    m_pend = 4'b0000; m_valid = 1'b0; m_y = 2'd0; m_last = 2'd0;
    rst = 1'b1; bus.en = 1'b0; bus.d = 4'b0000; bus.ready = 1'b0;
    test_reset();
    test_single();
    test_two();
    test_hold();
    test_rearm();
    test_en_rst();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
